// File: rtl/sp_mem_arbiter.sv
// sp_mem_arbiter: round-robin arbiter that shares one single-port synchronous-read RAM
// among NREQ requesters, with an optional zero-fill of the whole array after reset.
module sp_mem_arbiter #(
    parameter int NREQ          = 2,
    parameter int DATAWIDTH     = 8,
    parameter int DATADEPTH     = 1024,
    parameter int ADDRESSWIDTH  = $clog2(DATADEPTH),
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_write,
    input  logic [NREQ*ADDRESSWIDTH-1:0] req_addr,
    input  logic [NREQ*DATAWIDTH-1:0]    req_wdata,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [DATAWIDTH-1:0]         rsp_rdata,
    output logic                         init_done,
    output logic                         mem_write_en,
    output logic [ADDRESSWIDTH-1:0]      mem_address,
    output logic [DATAWIDTH-1:0]         mem_data_in,
    input  logic [DATAWIDTH-1:0]         mem_data_out
);
    localparam int AW = ADDRESSWIDTH;
    localparam int DW = DATAWIDTH;
    localparam int PW = $clog2(NREQ);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [0:0] START = INIT_ON_RESET ? INIT : RUN;

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win;
    logic          hit;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        win = '0;
        hit = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (state == RUN && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                win = PW'((int'(rr_ptr) + k) % NREQ);
                hit = 1'b1;
            end
        end
    end

    assign req_ready    = hit ? (NREQ'(1) << win) : '0;
    assign init_done    = state == RUN;
    assign rsp_rdata    = mem_data_out;
    assign mem_write_en = (state == INIT) | (hit & req_write[win]);
    // Idle cycles replay the last address/data so the RAM pins do not toggle.
    assign mem_address  = state == INIT ? cnt : hit ? req_addr[int'(win)*AW +: AW] : addr_q;
    assign mem_data_in  = state == INIT ? '0 : hit ? req_wdata[int'(win)*DW +: DW] : data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= START;
            cnt       <= '0;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            addr_q    <= mem_address;
            data_q    <= mem_data_in;
            rsp_valid <= req_ready;
            if (state == INIT) begin
                if (cnt == AW'(DATADEPTH - 1)) state <= RUN;
                else cnt <= cnt + 1'b1;
            end
            if (hit) rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end
endmodule

// File: tb/tb_sp_mem_arbiter.sv
// tb_sp_mem_arbiter: randomized and directed checks of sp_mem_arbiter against a
// behavioural model of arbitration order, memory contents and response timing.
module tb_sp_mem_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              init_done;
    logic              mem_write_en;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_data_in;
    logic [DW-1:0]     mem_data_out;

    sp_mem_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .DATADEPTH(DEPTH), .ADDRESSWIDTH(AW),
                     .INIT_ON_RESET(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .mem_write_en(mem_write_en), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out));

    always #5 clk = ~clk;

    // Write-through single-port RAM attached to the arbiter.
    logic [DW-1:0] ram [DEPTH];
    always_ff @(posedge clk) begin
        if (mem_write_en) ram[mem_address] <= mem_data_in;
        mem_data_out <= mem_write_en ? mem_data_in : ram[mem_address];
    end

    int n_checks = 0;
    int n_fail = 0;

    bit v [NREQ];
    bit w [NREQ];
    int a [NREQ];
    int d [NREQ];

    bit m_init;
    int m_cnt, m_rr, m_last_addr, m_last_data, m_rsp_id, m_rsp_data;
    bit m_rsp_pend;
    int ref_mem [DEPTH];
    int g_win;
    logic [NREQ-1:0] g_ready;
    logic [AW-1:0]   g_addr;
    logic            g_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_init = 1; m_cnt = 0; m_rr = 0; m_rsp_pend = 0;
        m_last_addr = 0; m_last_data = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = v[i];
            req_write[i] = w[i];
            req_addr[i*AW +: AW] = AW'(a[i]);
            req_wdata[i*DW +: DW] = DW'(d[i]);
        end
    endtask

    task automatic compare();
        int win = -1;
        if (!m_init)
            for (int k = 0; k < NREQ; k++)
                if (win < 0 && v[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
        g_win = win;
        g_ready = req_ready;
        g_addr = mem_address;
        g_we = mem_write_en;
        chk("ready", req_ready, win < 0 ? 0 : 1 << win);
        chk("init_done", init_done, m_init ? 0 : 1);
        chk("write_en", mem_write_en, m_init ? 1 : (win >= 0 && w[win]) ? 1 : 0);
        chk("address", mem_address, m_init ? m_cnt : win >= 0 ? a[win] : m_last_addr);
        chk("data_in", mem_data_in, m_init ? 0 : win >= 0 ? d[win] : m_last_data);
        chk("rsp_valid", rsp_valid, m_rsp_pend ? 1 << m_rsp_id : 0);
        if (m_rsp_pend) chk("rsp_rdata", rsp_rdata, m_rsp_data);
    endtask

    task automatic update();
        if (m_init) begin
            ref_mem[m_cnt] = 0;
            m_last_addr = m_cnt;
            m_last_data = 0;
            m_rsp_pend = 0;
            if (m_cnt == DEPTH - 1) m_init = 0;
            else m_cnt++;
        end else begin
            m_rsp_pend = g_win >= 0;
            if (g_win >= 0) begin
                if (w[g_win]) ref_mem[a[g_win]] = d[g_win];
                m_rsp_data = ref_mem[a[g_win]];
                m_rsp_id = g_win;
                m_rr = (g_win + 1) % NREQ;
                m_last_addr = a[g_win];
                m_last_data = d[g_win];
            end
        end
    endtask

    task automatic run_cycle();
        drive();
        @(negedge clk);
        compare();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 0; w[i] = 0; a[i] = 0; d[i] = 0;
        end
    endtask

    task automatic randomize_reqs();
        for (int i = 0; i < NREQ; i++)
            if (!(v[i] && !g_ready[i])) begin
                v[i] = $urandom_range(0, 2) != 0;
                w[i] = 1'($urandom_range(0, 1));
                a[i] = $urandom_range(0, DEPTH - 1);
                d[i] = $urandom_range(0, 255);
            end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear_reqs();
        drive();
        model_reset();
        g_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_init_done", init_done, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_ready", req_ready, 0);
        reset_n = 1'b1;

        for (int c = 0; c < DEPTH; c++) begin
            run_cycle();
            if (c == 0) begin
                chk("init_first_addr", g_addr, 0);
                chk("init_first_we", g_we, 1);
            end
        end
        chk("init_done_rise", init_done, 1);

        // Never-written address reads back zero.
        v[0] = 1; a[0] = 3;
        run_cycle();
        chk("unwritten_rsp_valid", rsp_valid, 4'b0001);
        chk("unwritten_rdata", rsp_rdata, 8'h00);
        clear_reqs();

        v[1] = 1; w[1] = 1; a[1] = 16; d[1] = 8'hA5;
        run_cycle();
        chk("wr_ready", g_ready, 4'b0010);
        chk("wr_rsp_valid", rsp_valid, 4'b0010);
        chk("wr_rdata", rsp_rdata, 8'hA5);
        clear_reqs();
        v[2] = 1; a[2] = 16;
        run_cycle();
        chk("rd_ready", g_ready, 4'b0100);
        chk("rd_rsp_valid", rsp_valid, 4'b0100);
        chk("rd_rdata", rsp_rdata, 8'hA5);
        clear_reqs();

        v[3] = 1;
        for (int c = 0; c < 5; c++) begin
            a[3] = c;
            run_cycle();
            chk("solo_ready", g_ready, 4'b1000);
        end

        // Pointer wrapped to 0 after the solo grants, so rotation starts at requester 0.
        for (int i = 0; i < NREQ; i++) begin v[i] = 1; a[i] = i + 8; end
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            chk("rr_ready", g_ready, 1 << (c % NREQ));
            chk("rr_rsp_valid", rsp_valid, 1 << (c % NREQ));
        end
        clear_reqs();

        for (int c = 0; c < 400; c++) begin
            randomize_reqs();
            run_cycle();
        end

        for (int i = 0; i < NREQ; i++) begin v[i] = 1; w[i] = 0; end
        run_cycle();
        chk("inflight_rsp", rsp_valid != 0, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", rsp_valid, 0);
        chk("midreset_init_done", init_done, 0);
        chk("midreset_addr", mem_address, 0);
        chk("midreset_we", mem_write_en, 1);
        chk("midreset_ready", req_ready, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        clear_reqs();
        g_ready = '0;
        for (int c = 0; c < DEPTH; c++) begin
            run_cycle();
            if (c == 0) chk("reinit_first_addr", g_addr, 0);
        end
        for (int c = 0; c < 100; c++) begin
            randomize_reqs();
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
